uart_rx_core: RTL

Parametrised UART receive engine with an on-chip receive FIFO, the next-generation receiver for the MiniUart peripheral. It samples the serial line on an external oversample enable and supports configurable data width, oversample ratio and stop-bit count. Parity mode is selectable at run time, and framing, parity and overrun errors are detected. Received words are queued in a first-word-fall-through FIFO that the CPU-side bus interface drains.

---
 rtl/uart_rx_core_if.sv | 27 ++
 rtl/uart_rx_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - CPU-side receive FIFO and error-flag bus for uart_rx_core
// master = bus interface draining the FIFO, slave = receive engine.
interface uart_rx_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rd;
  logic                 clr_err;
  logic [DATA_BITS-1:0] d_out;
  logic                 rx_valid;
  logic [CW-1:0]        count;
  logic                 frame_err;
  logic                 par_err;
  logic                 ovf;

  modport master (
    output rd, clr_err,
    input  d_out, rx_valid, count, frame_err, par_err, ovf
  );

  modport slave (
    input  rd, clr_err,
    output d_out, rx_valid, count, frame_err, par_err, ovf
  );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/framing/overrun checks and FWFT FIFO
// Line decisions use the synchronised rxs; the FSM only advances on en_rx ticks.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_rx,
  input  logic            rxd,
  input  logic [1:0]      par_mode,
  uart_rx_core_if.slave   bus
);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic                 rxd_m, rxs;
  logic [2:0]           state;
  logic [SCW-1:0]       samp_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           par_r;
  logic                 par_bad;
  logic                 push_req;
  logic                 fe_req;
  logic                 samp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxs   <= rxd_m;
    end
  end

  assign samp = (samp_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_r    <= 2'd0;
      par_bad  <= 1'b0;
      push_req <= 1'b0;
      fe_req   <= 1'b0;
    end else begin
      push_req <= 1'b0;
      fe_req   <= 1'b0;
      if (en_rx) begin
        if (state != IDLE && state != WAIT_IDLE)
          samp_cnt <= samp ? SCW'(OVERSAMPLE - 1) : samp_cnt - SCW'(1);
        case (state)
          IDLE: begin
            if (!rxs) begin
              par_r    <= par_mode;
              samp_cnt <= SCW'(OVERSAMPLE / 2 - 1);
              bit_cnt  <= 3'(DATA_BITS - 1);
              par_bad  <= 1'b0;
              state    <= START;
            end
          end
          START: begin
            if (samp) state <= rxs ? IDLE : DATA;
          end
          DATA: begin
            if (samp) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == 3'd0) begin
                // bit_cnt is reused to count stop bits
                bit_cnt <= 3'(STOP_BITS - 1);
                state   <= (par_r == 2'd1 || par_r == 2'd2) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          PARITY: begin
            if (samp) begin
              par_bad <= (rxs != ((^shreg) ^ (par_r == 2'd1)));
              state   <= STOP;
            end
          end
          STOP: begin
            if (samp) begin
              if (!rxs) begin
                fe_req <= 1'b1;
                state  <= WAIT_IDLE;
              end else if (bit_cnt == 3'd0) begin
                push_req <= 1'b1;
                state    <= IDLE;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          WAIT_IDLE: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 full, do_rd, do_wr, ovf_evt;

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign do_rd   = bus.rd && (cnt != '0);
  // A pop in the same cycle frees the slot the push lands in
  assign do_wr   = push_req && (!full || do_rd);
  assign ovf_evt = push_req && full && !do_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      bus.frame_err <= 1'b0;
      bus.par_err   <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      bus.frame_err <= fe_req || (bus.frame_err && !bus.clr_err);
      bus.par_err   <= (push_req && par_bad) || (bus.par_err && !bus.clr_err);
      bus.ovf       <= ovf_evt || (bus.ovf && !bus.clr_err);
    end
  end

  assign bus.d_out    = mem[rd_ptr];
  assign bus.rx_valid = (cnt != '0);
  assign bus.count    = cnt;
endmodule
